// File: rtl/arb32_8_pkg.sv
// arb32_8_pkg
// Shared definitions for the two-channel arbiter / slot sequencer that feeds
// the 32-to-8 byte unstriper.
//   state_e   : arbitration FSM states (idle, channel 0 owns, channel 1 owns)
//   SLOT_LAST : slot counter value of the boundary cycle
//   WORD_W    : width of a source word
//   BURST_W   : width of the burst counter (MAX_BURST is at most 15)
package arb32_8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic [1:0] SLOT_LAST = 2'd3;
  localparam int         WORD_W    = 32;
  localparam int         BURST_W   = 4;

endpackage

// File: rtl/arb32_8_slot.sv
// arb32_8_slot
// Free-running 2-bit slot counter. One slot is four clk_4f cycles, the rate at
// which the converter consumes a 32-bit word.
//   clk_4f   in  byte-rate clock
//   reset    in  asynchronous, active-high reset
//   boundary out high during the last cycle of every slot
module arb32_8_slot
  import arb32_8_pkg::*;
(
  input  logic clk_4f,
  input  logic reset,
  output logic boundary
);

  logic [1:0] slot_cnt_q;
  logic [1:0] slot_cnt_d;

  // The counter wraps naturally, so the next value is always +1.
  always_comb begin
    slot_cnt_d = slot_cnt_q + 2'd1;
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      slot_cnt_q <= 2'd0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
    end
  end

  assign boundary = (slot_cnt_q == SLOT_LAST);

endmodule

// File: rtl/arb32_8.sv
// arb32_8
// Shares one 32-to-8 unstriper between two 32-bit word sources. A winner is
// picked once per 4-cycle slot, at the boundary cycle; the accepted word is
// then held on data_strp/valid_strp for the whole next slot. Grants are sticky
// up to MAX_BURST consecutive words while the other channel is waiting, and
// ties out of idle go to the channel that did not own the bus last.
//   clk_4f     in   byte-rate clock (converter clock)
//   reset      in   asynchronous, active-high reset
//   enable     in   sampled at the boundary; low blocks new grants
//   data_in0   in   channel 0 word        valid_in0 in  channel 0 valid
//   ready_out0 out  channel 0 pop strobe (combinational)
//   data_in1   in   channel 1 word        valid_in1 in  channel 1 valid
//   ready_out1 out  channel 1 pop strobe (combinational)
//   data_strp  out  word presented to the converter
//   valid_strp out  data_strp valid for the current slot
//   grant_id   out  channel that owns the current slot
//   busy       out  FSM is not idle
module arb32_8
  import arb32_8_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              enable,
  input  logic [WORD_W-1:0] data_in0,
  input  logic              valid_in0,
  output logic              ready_out0,
  input  logic [WORD_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic              ready_out1,
  output logic [WORD_W-1:0] data_strp,
  output logic              valid_strp,
  output logic              grant_id,
  output logic              busy
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  logic boundary;

  state_e              state_q, state_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic                last_owner_q, last_owner_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                grant_q, grant_d;

  logic   burst_full;
  logic   win_valid;
  logic   win_id;
  logic   take;
  state_e win_state;

  arb32_8_slot u_slot (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .boundary (boundary)
  );

  assign burst_full = (burst_cnt_q == BURST_MAX);

  // Winner selection. win_valid implies the winner's own valid is high, so the
  // ready strobes below need no extra valid qualification.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in0 && valid_in1) begin
          win_valid = 1'b1;
          win_id    = ~last_owner_q;
        end else if (valid_in0 || valid_in1) begin
          win_valid = 1'b1;
          win_id    = valid_in1;
        end
      end
      ST_OWN0: begin
        if (valid_in0 && !(burst_full && valid_in1)) begin
          win_valid = 1'b1;
          win_id    = 1'b0;
        end else if (valid_in1) begin
          win_valid = 1'b1;
          win_id    = 1'b1;
        end
      end
      ST_OWN1: begin
        if (valid_in1 && !(burst_full && valid_in0)) begin
          win_valid = 1'b1;
          win_id    = 1'b1;
        end else if (valid_in0) begin
          win_valid = 1'b1;
          win_id    = 1'b0;
        end
      end
      default: begin
        win_valid = 1'b0;
        win_id    = 1'b0;
      end
    endcase
  end

  assign take       = boundary && enable && win_valid;
  assign ready_out0 = take && !win_id;
  assign ready_out1 = take &&  win_id;
  assign win_state  = win_id ? ST_OWN1 : ST_OWN0;

  // Next-state logic: everything only moves at the boundary cycle. A boundary
  // without a transfer drops valid and returns to idle, but keeps the old word
  // and grant_id on the outputs.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    data_d       = data_q;
    valid_d      = valid_q;
    grant_d      = grant_q;
    if (boundary) begin
      if (take) begin
        data_d       = win_id ? data_in1 : data_in0;
        valid_d      = 1'b1;
        grant_d      = win_id;
        last_owner_d = win_id;
        state_d      = win_state;
        if (state_q == win_state) begin
          burst_cnt_d = burst_full ? burst_cnt_q : burst_cnt_q + BURST_W'(1);
        end else begin
          burst_cnt_d = BURST_W'(1);
        end
      end else begin
        valid_d     = 1'b0;
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      burst_cnt_q  <= '0;
      last_owner_q <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      grant_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      grant_q      <= grant_d;
    end
  end

  assign data_strp  = data_q;
  assign valid_strp = valid_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
